// File: rtl/wide_add_seq.sv
// Multi-beat wide adder/subtractor: one 32-bit word per beat, LS word first,
// inter-word carry held locally, result words on a registered valid/ready stream.

// Unregistered 32-bit Kogge-Stone prefix adder (no carry-in).
module prefix_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        cout
);
  logic [5:0][31:0] g;
  logic [4:0][31:0] p;

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  for (genvar k = 0; k < 5; k++) begin : g_lvl
    for (genvar i = 0; i < 32; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_op
        assign g[k+1][i] = g[k][i] | (p[k][i] & g[k][i-(1<<k)]);
        if (k < 4) begin : g_p
          assign p[k+1][i] = p[k][i] & p[k][i-(1<<k)];
        end
      end else begin : g_pass
        assign g[k+1][i] = g[k][i];
        if (k < 4) begin : g_p
          assign p[k+1][i] = p[k][i];
        end
      end
    end
  end

  // g[5][i] is the carry out of bit i
  assign s    = p[0] ^ {g[5][30:0], 1'b0};
  assign cout = g[5][31];
endmodule

module wide_add_seq #(
  parameter int MAX_WORDS = 8,
  parameter int W         = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_a,
  input  logic [W-1:0]                 in_b,
  input  logic                         in_sub,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_sum,
  output logic                         out_last,
  output logic [$clog2(MAX_WORDS)-1:0] out_beat,
  output logic                         out_cout,
  output logic                         out_ovf,
  output logic                         out_err
);
  localparam int BW = $clog2(MAX_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] beat, beat_nx;
  logic          carry, sub_q;

  logic          accept, first, sub_eff, cin;
  logic [W-1:0]  bx, core_s, sum;
  logic          core_co, cw, at_max, last_eff, trunc, ovf;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign first    = (state == IDLE);

  // in_sub only matters on the first beat; later beats use the latched mode
  assign sub_eff  = first ? in_sub : sub_q;
  assign cin      = first ? in_sub : carry;
  assign bx       = sub_eff ? ~in_b : in_b;

  prefix_add32 u_core (
    .a    (in_a),
    .b    (bx),
    .s    (core_s),
    .cout (core_co)
  );

  assign sum      = core_s + {{(W-1){1'b0}}, cin};
  assign cw       = core_co | (cin & (&core_s));
  assign at_max   = (beat == BW'(MAX_WORDS - 1));
  assign last_eff = in_last | at_max;
  assign trunc    = at_max & !in_last;
  assign ovf      = (in_a[W-1] == bx[W-1]) & (sum[W-1] != in_a[W-1]);

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    if (accept) begin
      if (last_eff) begin
        state_nx = IDLE;
        beat_nx  = '0;
      end else begin
        state_nx = BUSY;
        beat_nx  = beat + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      if (accept) begin
        carry <= last_eff ? 1'b0 : cw;
        if (first) sub_q <= in_sub;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_beat  <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_last  <= last_eff;
      out_beat  <= beat;
      out_cout  <= last_eff & cw;
      out_ovf   <= last_eff & ovf;
      out_err   <= trunc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
